// File: rtl/fft_quad_feeder.sv
// ============================================================================
// Module      : fft_quad_feeder
// Description : Ping-pong frame buffer feeding radix-4 DIF quadruples
//               (x[k], x[k+N/4], x[k+N/2], x[k+3N/4]) to the first butterfly.
//               Optional macro FFT_FEEDER_PRESCALE_EN: samples >>> 2 before packing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_quad_feeder #(
    parameter int WIDTH = 24,
    parameter int N     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH/2-1:0]       sample_in,
    input  logic                     sample_valid,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic [WIDTH-1:0]         c,
    output logic [WIDTH-1:0]         d,
    output logic                     quad_valid,
    input  logic                     quad_ready,
    output logic                     frame_first,
    output logic                     frame_last,
    output logic                     overrun
);

    localparam int HALF_WIDTH = WIDTH / 2;
    localparam int AW         = $clog2(N);
    localparam int KW         = (N > 4) ? $clog2(N / 4) : 1;
    localparam logic [KW-1:0] C_K_LAST   = KW'(N / 4 - 1);
    localparam logic [AW-1:0] C_CNT_LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    logic [HALF_WIDTH-1:0]      r_mem [2*N];
    state_t                     r_state;
    logic                       r_wr_bank;
    logic                       r_rd_bank;
    logic                       r_wr_full;
    logic [AW-1:0]              r_wr_cnt;
    logic [KW-1:0]              r_k;
    logic [3:0][WIDTH-1:0]      r_q;
    logic                       r_valid;
    logic                       r_first;
    logic                       r_last;
    logic                       r_overrun;

    logic                       w_hs;
    logic                       w_rd_done;
    logic                       w_rd_free;
    logic                       w_wr_en;
    logic                       w_wr_last;
    logic                       w_swap;
    logic [KW-1:0]              w_kn;
    logic [3:0][WIDTH-1:0]      w_pk;

    assign w_hs      = r_valid && quad_ready;
    assign w_rd_done = (r_state == S_STREAM) && w_hs && (r_k == C_K_LAST);
    assign w_rd_free = (r_state == S_IDLE) || w_rd_done;
    assign w_wr_en   = sample_valid && !r_wr_full;
    assign w_wr_last = w_wr_en && (r_wr_cnt == C_CNT_LAST);
    // A pending full bank swaps the moment the reader frees up.
    assign w_swap    = (w_wr_last || r_wr_full) && w_rd_free;
    assign w_kn      = (r_state == S_STREAM) ? r_k + KW'(1) : r_k;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= sample_in;
        end
    end

    // Read port for each of the four lanes, addressing quad w_kn.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [AW-1:0]                w_addr;
        logic signed [HALF_WIDTH-1:0] w_s;
        logic signed [HALF_WIDTH-1:0] w_scaled;
        assign w_addr = AW'(w_kn) + AW'(i * (N / 4));
        assign w_s    = r_mem[{r_rd_bank, w_addr}];
`ifdef FFT_FEEDER_PRESCALE_EN
        assign w_scaled = w_s >>> 2;
`else
        assign w_scaled = w_s;
`endif
        assign w_pk[i] = {w_scaled, {HALF_WIDTH{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b1;
            r_wr_full <= 1'b0;
            r_wr_cnt  <= '0;
            r_k       <= '0;
            r_q       <= '0;
            r_valid   <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (sample_valid && r_wr_full) begin
                r_overrun <= 1'b1;
            end

            if (w_swap) begin
                r_rd_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
                r_wr_cnt  <= '0;
                r_wr_full <= 1'b0;
            end else if (w_wr_last) begin
                r_wr_full <= 1'b1;
            end else if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + AW'(1);
            end

            case (r_state)
                S_IDLE: ;
                S_LOAD: begin
                    r_q     <= w_pk;
                    r_first <= (w_kn == '0);
                    r_last  <= (w_kn == C_K_LAST);
                    r_valid <= 1'b1;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (r_k == C_K_LAST) begin
                            r_valid <= 1'b0;
                            r_first <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_k     <= w_kn;
                            r_q     <= w_pk;
                            r_first <= 1'b0;
                            r_last  <= (w_kn == C_K_LAST);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // The newly swapped bank always restarts at quad 0.
            if (w_swap) begin
                r_k     <= '0;
                r_state <= S_LOAD;
            end
        end
    end

    assign a           = r_q[0];
    assign b           = r_q[1];
    assign c           = r_q[2];
    assign d           = r_q[3];
    assign quad_valid  = r_valid;
    assign frame_first = r_first;
    assign frame_last  = r_last;
    assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_fft_quad_feeder.sv
// ============================================================================
// Module      : tb_fft_quad_feeder
// Description : Scoreboard bench for fft_quad_feeder (N=16, WIDTH=24).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_quad_feeder;

    logic        clk;
    logic        rst;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic [23:0] a, b, c, d;
    logic        quad_valid;
    logic        quad_ready;
    logic        frame_first;
    logic        frame_last;
    logic        overrun;

    int n_checks;
    int n_errors;
    int fr[16];
    logic [97:0] sb[$];

    fft_quad_feeder #(.WIDTH(24), .N(16)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .a(a), .b(b), .c(c), .d(d), .quad_valid(quad_valid), .quad_ready(quad_ready),
        .frame_first(frame_first), .frame_last(frame_last), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input int s);
        logic signed [11:0] v;
        v = 12'(s);
`ifdef FFT_FEEDER_PRESCALE_EN
        v = v >>> 2;
`endif
        return {v, 12'h000};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic feed(input int v);
        sample_in    = 12'(v);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic feed_frame();
        for (int i = 0; i < 16; i++) feed(fr[i]);
    endtask

    task automatic push_frame();
        for (int k = 0; k < 4; k++)
            sb.push_back({pk(fr[k]), pk(fr[k+4]), pk(fr[k+8]), pk(fr[k+12]),
                          (k == 0), (k == 3)});
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every handshake must match the oldest expected quad.
    always @(negedge clk) begin
        if (!rst && quad_valid && quad_ready) begin
            logic [97:0] act;
            logic [97:0] exp;
            act = {a, b, c, d, frame_first, frame_last};
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL quad_unexpected: got %0h expected none", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_errors++;
                    $display("FAIL quad: got %0h expected %0h", act, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; sample_in = '0; sample_valid = 1'b0; quad_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ab", {a, b}, 64'd0);
        chk("rst_cd", {c, d}, 64'd0);
        chk("rst_flags", {quad_valid, frame_first, frame_last, overrun}, 64'd0);
        rst = 1'b0;

        // Full frame, ready held high
        for (int i = 0; i < 16; i++) fr[i] = 10 * i;
        push_frame();
        feed_frame();
        chk("ff_valid_load", quad_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("ff_valid_run", quad_valid, 1'b1);
        end
        @(posedge clk); #1;
        chk("ff_valid_end", quad_valid, 1'b0);
        drain(cyc);

        // Backpressure on quad1
        for (int i = 0; i < 16; i++) fr[i] = 10 * i + 1;
        push_frame();
        feed_frame();
        @(posedge clk); #1;
        @(posedge clk); #1;
        quad_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_ab", {a, b}, {pk(11), pk(51)});
            chk("bp_cd", {c, d}, {pk(91), pk(131)});
            chk("bp_flags", {quad_valid, frame_first, frame_last}, 3'b100);
        end
        quad_ready = 1'b1;
        drain(cyc);

        // Overrun: two frames queued, third frame's first sample dropped
        quad_ready = 1'b0;
        for (int i = 0; i < 16; i++) fr[i] = 200 + i;
        push_frame();
        feed_frame();
        for (int i = 0; i < 16; i++) fr[i] = 300 + i;
        push_frame();
        feed_frame();
        chk("ovr_before", overrun, 1'b0);
        feed(999);
        chk("ovr_set", overrun, 1'b1);
        quad_ready = 1'b1;
        drain(cyc);
        chk("ovr_b_follows", 64'(cyc), 64'd9);
        chk("ovr_sticky", overrun, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // Frame B completes on frame A's last handshake
        quad_ready = 1'b0;
        for (int i = 0; i < 16; i++) fr[i] = 400 + i;
        push_frame();
        feed_frame();
        for (int i = 0; i < 16; i++) fr[i] = 500 + i;
        push_frame();
        for (int i = 0; i < 15; i++) feed(fr[i]);
        quad_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        feed(fr[15]);
        chk("sim_gap", quad_valid, 1'b0);
        @(posedge clk); #1;
        chk("sim_valid", quad_valid, 1'b1);
        chk("sim_a", a, pk(500));
        chk("sim_ovr", overrun, 1'b0);
        drain(cyc);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 7; i++) feed(50 + i);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ab", {a, b}, 64'd0);
        chk("mid_rst_cd", {c, d}, 64'd0);
        chk("mid_rst_flags", {quad_valid, frame_first, frame_last, overrun}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) fr[i] = 100 + i;
        push_frame();
        feed_frame();
        drain(cyc);

        // Sign handling
        fr[0] = -100;
        for (int i = 1; i < 16; i++) fr[i] = -3 * i;
        push_frame();
        feed_frame();
        @(posedge clk); #1;
        chk("sign_valid", quad_valid, 1'b1);
`ifdef FFT_FEEDER_PRESCALE_EN
        chk("sign_re", a[23:12], 12'hFE7);
`else
        chk("sign_re", a[23:12], 12'hF9C);
`endif
        chk("sign_im", a[11:0], 12'h000);
        drain(cyc);
        @(posedge clk); #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
